// File: rtl/ra_pq_p.sv
// Parametrised sorted register-array priority queue: one request is captured in IDLE, applied in SHIFT.
// Optional sticky overflow/underflow flags are enabled by defining RA_PQ_P_ERR_EN.
module ra_pq_p #(
   parameter int DEPTH    = 16,
   parameter int KW       = 8,
   parameter int VW       = 8,
   parameter int MAX_MODE = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [KW-1:0]                key_i,
   input  logic [VW-1:0]                val_i,
   input  logic                         enq,
   input  logic                         deq,
   input  logic                         replace,
   output logic [KW-1:0]                key_o,
   output logic [VW-1:0]                val_o,
   output logic                         busy,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef RA_PQ_P_ERR_EN
   ,
   output logic                         err_ovf,
   output logic                         err_unf
`endif
);

   localparam int CW = $clog2(DEPTH+1);

   typedef enum logic {IDLE, SHIFT} state_t;
   typedef enum logic [1:0] {OP_NONE, OP_ENQ, OP_DEQ, OP_REP} op_t;

   state_t           state_q, state_d;
   op_t              op_p0, op_d;
   logic [KW-1:0]    key_p0;
   logic [VW-1:0]    val_p0;
   logic [DEPTH-1:0] gt_p0, gt_d;

   logic [KW-1:0]    ent_key [DEPTH];
   logic [VW-1:0]    ent_val [DEPTH];
   logic [DEPTH-1:0] ent_vld;
   logic [CW-1:0]    count_q;

   logic [KW-1:0]    nxt_key [DEPTH];
   logic [VW-1:0]    nxt_val [DEPTH];
   logic [DEPTH-1:0] nxt_vld;
   logic [CW-1:0]    nxt_count;

   // Strict comparison: an equal key never overtakes, which gives the FIFO tie-break.
   function automatic logic precedes(input logic [KW-1:0] a, input logic [KW-1:0] b);
      if (MAX_MODE != 0) return a > b;
      else               return a < b;
   endfunction

   assign busy  = (state_q == SHIFT);
   assign count = count_q;
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign key_o = ent_vld[0] ? ent_key[0] : '0;
   assign val_o = ent_vld[0] ? ent_val[0] : '0;

   // Stage p0: decode request and register the compare vector
   always_comb begin
      state_d = state_q;
      op_d    = op_p0;
      gt_d    = '0;
      case (state_q)
         IDLE: begin
            if (replace || (enq && deq)) op_d = OP_REP;
            else if (deq)                op_d = OP_DEQ;
            else if (enq)                op_d = OP_ENQ;
            else                         op_d = OP_NONE;
            if (op_d != OP_NONE) state_d = SHIFT;
            if (op_d == OP_REP) begin
               for (int i = 0; i < DEPTH-1; i++)
                  gt_d[i] = ent_vld[i+1] && precedes(key_i, ent_key[i+1]);
            end else begin
               for (int i = 0; i < DEPTH; i++)
                  gt_d[i] = ent_vld[i] && precedes(key_i, ent_key[i]);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Stage p1: array update applied on the SHIFT edge
   always_comb begin
      int   p;
      logic hit;
      nxt_key   = ent_key;
      nxt_val   = ent_val;
      nxt_vld   = ent_vld;
      nxt_count = count_q;
      p         = 0;
      hit       = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!hit && gt_p0[i]) begin
            p   = i;
            hit = 1'b1;
         end
      end
      case (op_p0)
         OP_ENQ: begin
            if (int'(count_q) < DEPTH) begin
               if (!hit) p = int'(count_q);
               for (int i = 1; i < DEPTH; i++) begin
                  if (i > p) begin
                     nxt_key[i] = ent_key[i-1];
                     nxt_val[i] = ent_val[i-1];
                     nxt_vld[i] = ent_vld[i-1];
                  end
               end
               for (int i = 0; i < DEPTH; i++) begin
                  if (i == p) begin
                     nxt_key[i] = key_p0;
                     nxt_val[i] = val_p0;
                     nxt_vld[i] = 1'b1;
                  end
               end
               nxt_count = count_q + CW'(1);
            end
         end
         OP_DEQ: begin
            if (count_q != '0) begin
               for (int i = 0; i < DEPTH-1; i++) begin
                  nxt_key[i] = ent_key[i+1];
                  nxt_val[i] = ent_val[i+1];
                  nxt_vld[i] = ent_vld[i+1];
               end
               nxt_vld[DEPTH-1] = 1'b0;
               nxt_count        = count_q - CW'(1);
            end
         end
         OP_REP: begin
            // Entries ahead of the insert point slide down over the removed head.
            if (!hit) p = (count_q == '0) ? 0 : int'(count_q) - 1;
            for (int i = 0; i < DEPTH-1; i++) begin
               if (i < p) begin
                  nxt_key[i] = ent_key[i+1];
                  nxt_val[i] = ent_val[i+1];
                  nxt_vld[i] = ent_vld[i+1];
               end
            end
            for (int i = 0; i < DEPTH; i++) begin
               if (i == p) begin
                  nxt_key[i] = key_p0;
                  nxt_val[i] = val_p0;
                  nxt_vld[i] = 1'b1;
               end
            end
            if (count_q == '0) nxt_count = CW'(1);
         end
         default: ;
      endcase
   end

`ifdef RA_PQ_P_ERR_EN
   logic ovf_hit, unf_hit;
   assign ovf_hit = (state_q == SHIFT) && (op_p0 == OP_ENQ) && full;
   assign unf_hit = (state_q == SHIFT) && (op_p0 == OP_DEQ) && empty;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         op_p0   <= OP_NONE;
         ent_vld <= '0;
         count_q <= '0;
`ifdef RA_PQ_P_ERR_EN
         err_ovf <= 1'b0;
         err_unf <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if (state_q == IDLE) op_p0 <= op_d;
         if (state_q == SHIFT) begin
            ent_vld <= nxt_vld;
            count_q <= nxt_count;
         end
`ifdef RA_PQ_P_ERR_EN
         err_ovf <= err_ovf | ovf_hit;
         err_unf <= err_unf | unf_hit;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == IDLE) begin
         key_p0 <= key_i;
         val_p0 <= val_i;
         gt_p0  <= gt_d;
      end
      if (state_q == SHIFT) begin
         ent_key <= nxt_key;
         ent_val <= nxt_val;
      end
   end

endmodule
